// File: rtl/regfile_pkg.sv
// Shared register-file sizing and types, used by the write bank and the read-port mux trees.
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int WIDTH    = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = NUM_REGS - 1;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_bank_wb_if.sv
// Write request / register-contents bundle between the pipeline and the write-side register bank.
interface reg_bank_wb_if;
    import regfile_pkg::*;

    logic                      RegWrite;
    reg_idx_t                  WriteRegister;
    word_t                     WriteData;
    logic [NUM_REGS*WIDTH-1:0] regs_out;
    logic                      pend_valid;
    reg_idx_t                  pend_addr;

    modport master (
        output RegWrite, WriteRegister, WriteData,
        input  regs_out, pend_valid, pend_addr
    );
    modport slave (
        input  RegWrite, WriteRegister, WriteData,
        output regs_out, pend_valid, pend_addr
    );
endinterface

// File: rtl/decoder_en.sv
// Index-to-one-hot decoder with a global enable; at most one output is high.
module decoder_en #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  onehot
);
    for (genvar k = 0; k < N; k++) begin : g_dec
        assign onehot[k] = en && (addr == AW'(k));
    end
endmodule

// File: rtl/reg_bank_wb.sv
// Write-side register bank: one-entry write-back stage, then commit; X31 reads as zero.
// Define REG_BANK_WRITE_BYPASS_EN to overlay the pending write onto regs_out.
module reg_bank_wb
    import regfile_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    reg_bank_wb_if.slave rf
);
    logic     pend_valid;
    reg_idx_t pend_addr;
    word_t    pend_data;

    logic [ZERO_REG-1:0]               wr_en;
    logic [NUM_REGS-1:0][WIDTH-1:0]    store;
    logic [NUM_REGS-1:0][WIDTH-1:0]    view;

    // Writes to X31 are dropped here so they never reach the decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= rf.RegWrite && (rf.WriteRegister != reg_idx_t'(ZERO_REG));
            pend_addr  <= rf.WriteRegister;
            pend_data  <= rf.WriteData;
        end
    end

    // The zero register has no storage, so it needs no enable line.
    decoder_en #(.N(ZERO_REG), .AW(ADDR_W)) u_dec (
        .en     (pend_valid),
        .addr   (pend_addr),
        .onehot (wr_en)
    );

    for (genvar i = 0; i < ZERO_REG; i++) begin : g_reg
        word_t q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)         q <= '0;
            else if (wr_en[i]) q <= pend_data;
        end
        assign store[i] = q;
    end
    assign store[ZERO_REG] = '0;

    always_comb begin
        view = store;
`ifdef REG_BANK_WRITE_BYPASS_EN
        // pend_addr is never X31 while pend_valid, so the zero slice is untouched.
        if (pend_valid) view[pend_addr] = pend_data;
`endif
    end

    assign rf.regs_out   = view;
    assign rf.pend_valid = pend_valid;
    assign rf.pend_addr  = pend_addr;
endmodule

// File: tb/tb_reg_bank_wb.sv
// Scoreboard bench for reg_bank_wb: stimulus queues expected pending/commit results, a negedge monitor checks them.
module tb_reg_bank_wb;
    import regfile_pkg::*;

`ifdef REG_BANK_WRITE_BYPASS_EN
    localparam int VIS = 0;
`else
    localparam int VIS = 1;
`endif

    typedef struct { int due; int idx; logic [63:0] exp; } rchk_t;
    typedef struct { int due; int addr; } pchk_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    rchk_t reg_q[$];
    pchk_t pend_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    reg_bank_wb_if rf();
    reg_bank_wb dut (.clk(clk), .reset(reset), .rf(rf));

    function automatic logic [63:0] slice(input int i);
        return rf.regs_out[i*WIDTH +: WIDTH];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic wr(input bit we, input int idx, input logic [63:0] d);
        @(negedge clk);
        rf.RegWrite      = we;
        rf.WriteRegister = reg_idx_t'(idx);
        rf.WriteData     = d;
        if (we && idx != ZERO_REG) begin
            pend_q.push_back('{cyc + 1, idx});
            reg_q.push_back('{cyc + 1 + VIS, idx, d});
        end
    endtask

    // Monitor: X31 and pending stage every cycle, queued register checks when due.
    initial forever begin
        @(negedge clk);
        chk("x31_zero", slice(ZERO_REG), 64'd0);
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            chk("pend_valid", 64'(rf.pend_valid), 64'd1);
            chk("pend_addr", 64'(rf.pend_addr), 64'(pend_q[0].addr));
            void'(pend_q.pop_front());
        end else begin
            chk("pend_idle", 64'(rf.pend_valid), 64'd0);
        end
        for (int k = reg_q.size() - 1; k >= 0; k--) begin
            if (reg_q[k].due == cyc) begin
                if (reg_q[k].idx < 0)
                    chk("all_zero", 64'(rf.regs_out !== '0), 64'd0);
                else
                    chk($sformatf("x%0d", reg_q[k].idx), slice(reg_q[k].idx), reg_q[k].exp);
                reg_q.delete(k);
            end
        end
    end

    initial begin
        int n;
        rf.RegWrite = 1'b0; rf.WriteRegister = '0; rf.WriteData = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_regs", 64'(rf.regs_out !== '0), 64'd0);
        chk("rst_pend_valid", 64'(rf.pend_valid), 64'd0);
        chk("rst_pend_addr", 64'(rf.pend_addr), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset asserted between capture and commit discards the pending write.
        @(negedge clk);
        rf.RegWrite = 1'b1; rf.WriteRegister = 5'd3; rf.WriteData = 64'hDEAD_BEEF;
        n = cyc + 1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pend", 64'(rf.pend_valid), 64'd0);
        chk("rst_async_regs", 64'(rf.regs_out !== '0), 64'd0);
        @(negedge clk);
        rf.RegWrite = 1'b0;
        reset = 1'b0;
        reg_q.push_back('{n + 1, 3, 64'd0});
        reg_q.push_back('{n + 1, -1, 64'd0});

        wr(1, 5, 64'h0123_4567_89AB_CDEF);
        wr(1, 31, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(1, 7, 64'h11);
        wr(1, 7, 64'h22);
        wr(1, 1, 64'hA);
        wr(1, 2, 64'hB);
        wr(0, 0, 64'd0);
        reg_q.push_back('{cyc + 1, 1, 64'hA});
        reg_q.push_back('{cyc + 1, 2, 64'hB});
        reg_q.push_back('{cyc + 1, 5, 64'h0123_4567_89AB_CDEF});
        reg_q.push_back('{cyc + 1, 7, 64'h22});
        reg_q.push_back('{cyc + 1, 3, 64'd0});
        wr(0, 0, 64'd0);

        for (int i = 0; i < ZERO_REG; i++) wr(1, i, 64'(i * 32'h0101));
        for (int i = 0; i < ZERO_REG; i++) reg_q.push_back('{cyc + 3, i, 64'(i * 32'h0101)});
        repeat (3) wr(0, 0, 64'd0);

        repeat (2) @(negedge clk);
        #1;
        chk("reg_q_drained", 64'(reg_q.size()), 64'd0);
        chk("pend_q_drained", 64'(pend_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- Write-side storage of the ARM register file. Holds 32 x 64-bit registers and feeds the flattened register contents straight into the downstream read-port 2:1 mux trees.
- Write requests pass through a one-entry pending (write-back) stage and are committed one clock edge later.
- X31 is hardwired to zero.

Parameters:
- NUM_REGS, 32, number of architectural registers; the last index is the zero register.
- WIDTH, 64, register width in bits.
- ADDR_W, 5, register index width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- RegWrite  input  1  write request strobe, sampled at the rising edge.
- WriteRegister  input  ADDR_W  destination register index.
- WriteData  input  WIDTH  data to write.
- regs_out  output  NUM_REGS*WIDTH  flattened register contents; register i occupies bits [i*WIDTH +: WIDTH]; feeds the read mux trees.
- pend_valid  output  1  a write is held in the pending stage.
- pend_addr  output  ADDR_W  index of the pending write.

Behaviour:
- Reset (asynchronous, while reset=1):
  - All registers = 0.
  - pend_valid=0, pend_addr=0, internal pend_data=0.
  - regs_out = all zeros.
  - Takes effect regardless of clk and overrides any write in flight. A pending write at reset assertion is discarded, not committed.
- Stage 1 (capture), at a rising edge with reset=0:
  - pend_valid <= RegWrite && (WriteRegister != NUM_REGS-1).
  - pend_addr <= WriteRegister; pend_data <= WriteData.
  - A write to X31 is dropped: it never sets pend_valid.
- Stage 2 (commit), on the same edge:
  - If pend_valid was 1 before the edge, register[pend_addr] <= pend_data.
  - Commit uses the pre-edge pending contents, so capture and commit happen simultaneously without conflict.
- Latency:
  - The write is sampled at edge N and is visible in regs_out after edge N+1.
  - Sustained throughput is one write per cycle; there is no stall or backpressure.
- Back-to-back writes to the same index: the later write wins. The earlier one commits at N+1 and is overwritten at N+2.
- Address decode:
  - A one-hot enable is generated from pend_addr gated by pend_valid.
  - Exactly zero or one register is enabled per cycle.
- Zero register: the slice for index NUM_REGS-1 in regs_out is constant 0 in all cycles, with no storage flops.
- WriteRegister values are always < NUM_REGS; no out-of-range handling is required.
- Between writes, all registers hold their value. No X propagation after reset.

Optional Feature:
- Macro: REG_BANK_WRITE_BYPASS_EN.
- Defined:
  - While pend_valid=1, regs_out slice [pend_addr] shows pend_data combinationally (pending overlay). All other slices show stored values.
  - Effective write-to-visible latency becomes 1 edge.
  - The X31 slice stays 0.
- Undefined:
  - regs_out shows committed storage only, with the 2-edge visibility described in Behaviour.
  - No overlay logic is synthesized.

Decomposition:
- Package regfile_pkg holds:
  - NUM_REGS, WIDTH, ADDR_W.
  - ZERO_REG = NUM_REGS-1.
  - typedef word_t (WIDTH-bit logic).
  - typedef reg_idx_t (ADDR_W-bit logic).
- Shared with the read-port mux trees.
- One natural sub-module: decoder_en (ADDR_W-to-NUM_REGS one-hot decoder with enable). Driven by pend_addr/pend_valid; its outputs gate each register's load.

Test Plan:
- Reset during activity: write X3=0xDEAD_BEEF, assert reset between edges N and N+1 -> reset takes effect immediately without a clock edge; after N+1, X3 = 0, pend_valid = 0, all regs_out = 0.
- Basic write: RegWrite=1, WriteRegister=5, WriteData=0x0123_4567_89AB_CDEF at edge N -> pend_valid=1 and pend_addr=5 after N; X5 slice = value after N+1; with bypass enabled, X5 slice = value already after N.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to index 31 -> pend_valid stays 0; X31 slice = 0 in every cycle.
- Back-to-back same index: X7=0x11 at edge N, X7=0x22 at edge N+1 -> X7=0x11 after N+1, X7=0x22 after N+2.
- Back-to-back different index plus idle: X1=0xA at N, X2=0xB at N+1, RegWrite=0 at N+2 -> both committed by N+2; pend_valid=0 after N+2; all other registers unchanged.
- Sweep: write register i with value i*0x0101 for i=0..30, then idle 2 cycles -> every slice i equals i*0x0101 and slice 31 = 0.
